// File: rtl/snake_move_sched.sv
// snake_move_sched: paces snake head moves with a level-dependent tick timer and issues
// them over a req/ack handshake. Define SNAKE_SPEEDUP_EN to let eat_food raise speed_lvl.
module snake_move_sched #(
  parameter int TICK_DIV   = 25_000_000,
  parameter int SPEED_STEP = 2_000_000,
  parameter int TICK_MIN   = 5_000_000,
  parameter int LVL_W      = 4,
  parameter int CNT_W      = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       gameStatus,
  input  logic             key1_press,
  input  logic             key2_press,
  input  logic             key3_press,
  input  logic             key4_press,
  input  logic             eat_food,
  input  logic             move_ack,
  output logic             move_req,
  output logic [1:0]       move_dir,
  output logic [LVL_W-1:0] speed_lvl
);
  localparam int PW = CNT_W + LVL_W;
  localparam logic [PW-1:0]    P_DIV   = PW'(TICK_DIV);
  localparam logic [PW-1:0]    P_STEP  = PW'(SPEED_STEP);
  localparam logic [PW-1:0]    P_MIN   = PW'(TICK_MIN);
  localparam logic [PW-1:0]    P_ONE   = PW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [1:0]       GS_PLAY    = 2'b01;
  localparam logic [1:0]       GS_RESTART = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_WAIT_TICK = 2'b01,
    S_REQ       = 2'b10,
    S_WAIT_ACK  = 2'b11
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [PW-1:0]    r_period;
  logic [1:0]       r_pend;
  logic [1:0]       r_dir;
  logic             r_req;
  logic [LVL_W-1:0] r_lvl;

  logic             w_play;
  logic             w_in_hs;
  logic             w_restart;
  logic             w_key_vld;
  logic             w_key_acc;
  logic [1:0]       w_key_dir;
  logic [PW-1:0]    w_step;
  logic [PW-1:0]    w_period_calc;
  logic [PW-1:0]    w_period_now;

  assign w_play    = (gameStatus == GS_PLAY);
  assign w_in_hs   = (r_state == S_REQ) || (r_state == S_WAIT_ACK);
  // An open handshake defers a restart until the datapath acknowledges.
  assign w_restart = (gameStatus == GS_RESTART) && (!w_in_hs || move_ack);
  assign w_key_acc = w_key_vld && w_play && (w_key_dir != (r_dir ^ 2'b01));

  // Move period for the current level, floored at TICK_MIN without underflow
  always_comb begin
    w_step = PW'(r_lvl) * P_STEP;
    if (w_step >= (P_DIV - P_MIN)) begin
      w_period_calc = P_MIN;
    end else begin
      w_period_calc = P_DIV - w_step;
    end
    if (r_cnt == {CNT_W{1'b0}}) begin
      w_period_now = w_period_calc;
    end else begin
      w_period_now = r_period;
    end
  end

  // Priority encode the direction keys (key1 highest)
  always_comb begin
    w_key_vld = 1'b1;
    w_key_dir = 2'b11;
    if (key1_press) begin
      w_key_dir = 2'b00;
    end else if (key2_press) begin
      w_key_dir = 2'b01;
    end else if (key3_press) begin
      w_key_dir = 2'b10;
    end else if (key4_press) begin
      w_key_dir = 2'b11;
    end else begin
      w_key_vld = 1'b0;
    end
  end

  // Move scheduler FSM, key capture and speed level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= {CNT_W{1'b0}};
      r_period <= P_DIV;
      r_pend   <= 2'b11;
      r_dir    <= 2'b11;
      r_req    <= 1'b0;
      r_lvl    <= {LVL_W{1'b0}};
    end else begin
      if (w_key_acc) begin
        r_pend <= w_key_dir;
      end
      case (r_state)
        S_IDLE: begin
          r_cnt <= {CNT_W{1'b0}};
          if (w_play) begin
            r_state <= S_WAIT_TICK;
          end
        end
        S_WAIT_TICK: begin
          if (r_cnt == {CNT_W{1'b0}}) begin
            r_period <= w_period_calc;
          end
          if (!w_play) begin
            r_state <= S_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
          end else if ({{LVL_W{1'b0}}, r_cnt} == (w_period_now - P_ONE)) begin
            // Request launches on the terminal count so it rises exactly one period after entry.
            r_state <= S_REQ;
            r_cnt   <= {CNT_W{1'b0}};
            r_req   <= 1'b1;
            r_dir   <= r_pend;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_REQ, S_WAIT_ACK: begin
          if (move_ack) begin
            r_req   <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
            r_state <= w_play ? S_WAIT_TICK : S_IDLE;
          end else begin
            r_state <= S_WAIT_ACK;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= {CNT_W{1'b0}};
          r_req   <= 1'b0;
        end
      endcase
      if (w_restart) begin
        r_pend  <= 2'b11;
        r_dir   <= 2'b11;
        r_state <= S_IDLE;
        r_cnt   <= {CNT_W{1'b0}};
      end
`ifdef SNAKE_SPEEDUP_EN
      if (w_restart) begin
        r_lvl <= {LVL_W{1'b0}};
      end else if (eat_food && (r_lvl != {LVL_W{1'b1}})) begin
        r_lvl <= r_lvl + LVL_W'(1);
      end
`else
      r_lvl <= {LVL_W{1'b0}};
`endif
    end
  end

`ifndef SNAKE_SPEEDUP_EN
  logic w_unused;
  assign w_unused = eat_food;
`endif

  assign move_req  = r_req;
  assign move_dir  = r_dir;
  assign speed_lvl = r_lvl;

endmodule

// File: tb/tb_snake_move_sched.sv
// Scoreboard bench for snake_move_sched: expected (direction, rise cycle) entries are queued
// as stimulus is driven and checked on every move_req rising edge.
module tb_snake_move_sched;
  localparam int TICK_DIV   = 10;
  localparam int SPEED_STEP = 2;
  localparam int TICK_MIN   = 4;
  localparam int LVL_W      = 3;
  localparam int CNT_W      = 5;
  localparam logic [1:0] GS_START = 2'b00, GS_PLAY = 2'b01, GS_DIE = 2'b10, GS_RESTART = 2'b11;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] gameStatus;
  logic key1_press, key2_press, key3_press, key4_press;
  logic eat_food, move_ack;
  logic move_req;
  logic [1:0] move_dir;
  logic [LVL_W-1:0] speed_lvl;

  typedef struct {
    logic [1:0] dir;
    int         cyc;
  } exp_t;
  exp_t sb_q[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rise_cnt = 0;
  int   next_rise;
  int   exp_lvl  = 0;
  logic last_req = 1'b0;
  logic prev_req = 1'b0;
  logic ack_auto = 1'b0;
  logic m_ack    = 1'b0;

  always #5 clk = ~clk;

  snake_move_sched #(
    .TICK_DIV(TICK_DIV), .SPEED_STEP(SPEED_STEP), .TICK_MIN(TICK_MIN),
    .LVL_W(LVL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .gameStatus(gameStatus),
    .key1_press(key1_press), .key2_press(key2_press),
    .key3_press(key3_press), .key4_press(key4_press),
    .eat_food(eat_food), .move_ack(move_ack),
    .move_req(move_req), .move_dir(move_dir), .speed_lvl(speed_lvl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int period_of(input int lvl);
    int p;
    p = TICK_DIV - lvl * SPEED_STEP;
    return (p < TICK_MIN) ? TICK_MIN : p;
  endfunction

  function automatic int lvl_after(input int lvl, input int pulses);
    int l;
    l = (lvl + pulses > 7) ? 7 : lvl + pulses;
`ifndef SNAKE_SPEEDUP_EN
    l = 0;
`endif
    return l;
  endfunction

  task automatic push(input logic [1:0] d);
    exp_t e;
    e.dir = d;
    e.cyc = next_rise;
    sb_q.push_back(e);
  endtask

  // One clock: sample just after the edge, score any request, then drive the ack model.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (move_req === 1'b1 && last_req !== 1'b1) begin
      rise_cnt++;
      chk("req_expected", (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("move_dir", move_dir, e.dir);
        chk("rise_cycle", cyc, e.cyc);
      end
    end
    last_req = move_req;
    move_ack = ack_auto ? prev_req : m_ack;
    prev_req = move_req;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_rise(input int bound);
    int start;
    start = rise_cnt;
    for (int i = 0; i < bound; i++) begin
      step();
      if (rise_cnt != start) return;
    end
    chk("rise_timeout", rise_cnt - start, 1);
  endtask

  task automatic press(input logic [3:0] k);
    {key1_press, key2_press, key3_press, key4_press} = k;
    step();
    {key1_press, key2_press, key3_press, key4_press} = 4'b0000;
  endtask

  task automatic pulse_eat(input int n);
    for (int i = 0; i < n; i++) begin
      eat_food = 1'b1;
      step();
      eat_food = 1'b0;
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    gameStatus = GS_START;
    {key1_press, key2_press, key3_press, key4_press} = 4'b0000;
    eat_food = 1'b0;
    move_ack = 1'b0;
    run(2);
    chk("rst_req", move_req, 0);
    chk("rst_dir", move_dir, 2'b11);
    chk("rst_lvl", speed_lvl, 0);
    rst = 1'b0;
    step();

    // Free-running play with ack following req by one cycle
    ack_auto = 1'b1;
    gameStatus = GS_PLAY;
    next_rise = cyc + 1 + period_of(0);
    push(2'b11);
    wait_rise(40);
    next_rise += 2 + period_of(0);
    push(2'b11);
    wait_rise(40);

    // Key priority and reversal rejection
    run(3);
    press(4'b0011);
    next_rise += 2 + period_of(0);
    push(2'b11);
    wait_rise(40);
    run(3);
    press(4'b0010);
    next_rise += 2 + period_of(0);
    push(2'b11);
    wait_rise(40);
    run(3);
    press(4'b1100);
    next_rise += 2 + period_of(0);
    push(2'b00);
    wait_rise(40);
    run(3);
    press(4'b0100);
    press(4'b1000);
    press(4'b0010);
    next_rise += 2 + period_of(0);
    push(2'b10);
    wait_rise(40);

    // Stalled ack with DIE mid-wait; keys during DIE must be ignored
    ack_auto = 1'b0;
    m_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) gameStatus = GS_DIE;
      key1_press = (i == 10);
      step();
      chk("hold_req", move_req, 1);
      chk("hold_dir", move_dir, 2'b10);
    end
    key1_press = 1'b0;
    m_ack = 1'b1;
    step();
    m_ack = 1'b0;
    step();
    chk("ack_drop", move_req, 0);
    pulse_eat(3);
    exp_lvl = lvl_after(0, 3);
    chk("lvl_after_3", speed_lvl, exp_lvl);
    run(30);
    chk("die_dir", move_dir, 2'b10);

    // Resume at the new speed
    ack_auto = 1'b1;
    gameStatus = GS_PLAY;
    next_rise = cyc + 1 + period_of(exp_lvl);
    push(2'b10);
    wait_rise(40);
    next_rise += 2 + period_of(exp_lvl);
    push(2'b00);
    run(3);
    press(4'b1000);
    wait_rise(40);

    // Restart during an open handshake takes effect when the ack lands
    gameStatus = GS_RESTART;
    step();
    chk("rst_defer_req", move_req, 1);
    chk("rst_defer_dir", move_dir, 2'b00);
    chk("rst_defer_lvl", speed_lvl, exp_lvl);
    step();
    chk("restart_req", move_req, 0);
    chk("restart_dir", move_dir, 2'b11);
    chk("restart_lvl", speed_lvl, 0);
    run(10);

    // Saturate the level, then check the period floor
    gameStatus = GS_START;
    pulse_eat(12);
    exp_lvl = lvl_after(0, 12);
    chk("lvl_saturate", speed_lvl, exp_lvl);
    gameStatus = GS_PLAY;
    next_rise = cyc + 1 + period_of(exp_lvl);
    push(2'b11);
    wait_rise(40);
    next_rise += 2 + period_of(exp_lvl);
    push(2'b11);
    wait_rise(40);

    // Asynchronous reset while waiting for ack
    ack_auto = 1'b0;
    m_ack = 1'b0;
    run(2);
    chk("pre_rst_req", move_req, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_req", move_req, 0);
    chk("async_rst_dir", move_dir, 2'b11);
    chk("async_rst_lvl", speed_lvl, 0);
    gameStatus = GS_START;
    step();
    rst = 1'b0;
    run(20);
    chk("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
